serial_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter (txStart/txData/txBusy) between NREQ byte-stream sources.

---
 rtl/serial_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART transmitter among NREQ byte sources.
// One cycle to arbitrate, then each byte takes WAIT->HOLD; txBusy stalls WAIT with no timeout.
module serial_tx_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              txBusy,
  output logic              txStart,
  output logic [7:0]        txData,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [CNTW-1:0]   pkt_count,
  output logic [7:0]        abort_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t            r_state;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_gidx;
  logic [NREQ-1:0]   r_grant;
  logic              r_last;
  logic [TW-1:0]     r_tmo;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;
  logic              r_busy;
  logic [CNTW-1:0]   r_pkt_cnt;
  logic [7:0]        r_abort_cnt;

  logic              w_found;
  logic [IW-1:0]     w_sel;
  logic [IW-1:0]     w_scan;
  logic              w_vld;
  logic              w_last;
  logic [7:0]        w_byte;

  function automatic logic [IW-1:0] f_next(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Cyclic scan starting at the round-robin pointer; first valid source wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_scan  = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[w_scan]) begin
        w_found = 1'b1;
        w_sel   = w_scan;
      end
      w_scan = f_next(w_scan);
    end
  end

  always_comb begin
    w_vld  = 1'b0;
    w_last = 1'b0;
    w_byte = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_grant[k]) begin
        w_vld  = req_valid[k];
        w_last = req_last[k];
        w_byte = req_data[8*k +: 8];
      end
    end
  end

  assign req_ready = (r_state == S_WAIT && !txBusy) ? (r_grant & req_valid) : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_grant     <= '0;
      r_last      <= 1'b0;
      r_tmo       <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_busy      <= 1'b0;
      r_pkt_cnt   <= '0;
      r_abort_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= NREQ'(1) << w_sel;
            r_gidx  <= w_sel;
            r_tmo   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_vld && !txBusy) begin
            r_tx_data  <= w_byte;
            r_tx_start <= 1'b1;
            r_last     <= w_last;
            r_tmo      <= '0;
            r_state    <= S_HOLD;
          end else if (!w_vld) begin
            // Only a source that has gone quiet mid-packet can time out.
            if (TIMEOUT != 0 && r_tmo == TW'(TIMEOUT - 1)) begin
              if (r_abort_cnt != 8'hFF) r_abort_cnt <= r_abort_cnt + 1'b1;
              r_grant <= '0;
              r_ptr   <= f_next(r_gidx);
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
        end
        S_HOLD: begin
          r_tx_start <= 1'b0;
          if (r_last) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
            r_ptr     <= f_next(r_gidx);
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign txStart     = r_tx_start;
  assign txData      = r_tx_data;
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign pkt_count   = r_pkt_cnt;
  assign abort_count = r_abort_cnt;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: two queue-driven sources and a simple UART busy model.
module tb_serial_tx_arbiter;

  localparam int UB = 3;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        txBusy;
  logic        txStart;
  logic [7:0]  txData;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] pkt_count;
  logic [7:0]  abort_count;

  serial_tx_arbiter #(.NREQ(2), .TIMEOUT(10), .CNTW(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .txBusy(txBusy), .txStart(txStart), .txData(txData),
    .grant(grant), .busy(busy), .pkt_count(pkt_count), .abort_count(abort_count)
  );

  typedef struct packed { logic [7:0] d; logic l; } item_t;

  item_t      sq0[$];
  item_t      sq1[$];
  logic [7:0] log_q[$];
  logic [1:0] took;
  int         ucnt;
  logic       force_busy;
  int         viol;
  int         n_chk;
  int         n_err;

  always #5 clk = ~clk;

  assign txBusy = (ucnt != 0) || force_busy;

  // Sources: present queue head, retire it once the handshake completed.
  always @(negedge clk) begin
    if (took[0] && sq0.size() > 0) void'(sq0.pop_front());
    if (took[1] && sq1.size() > 0) void'(sq1.pop_front());
    req_valid[0] = (sq0.size() > 0);
    if (sq0.size() > 0) begin req_data[7:0]  = sq0[0].d; req_last[0] = sq0[0].l; end
    req_valid[1] = (sq1.size() > 0);
    if (sq1.size() > 0) begin req_data[15:8] = sq1[0].d; req_last[1] = sq1[0].l; end
    #1;
    took = req_ready & req_valid;
    if ((req_ready & ~grant) != 2'b00) viol++;
  end

  // UART model: capture each started byte and stay busy for UB cycles.
  always @(negedge clk) begin
    if (txStart) begin
      log_q.push_back(txData);
      ucnt = UB;
    end else if (ucnt > 0) begin
      ucnt--;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int src, input logic [7:0] d, input logic l);
    if (src == 0) sq0.push_back('{d: d, l: l});
    else          sq1.push_back('{d: d, l: l});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_pkts(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (int'(pkt_count) == n) break;
      tick();
    end
    check(tag, pkt_count, n);
  endtask

  function automatic logic [7:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 8'hxx;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         base;
    int         k;
    logic [1:0] prev;
    logic [1:0] gseq[$];
    logic [7:0] exp2 [6];
    logic [7:0] exp6 [10];
    logic [1:0] gexp [5];

    exp2 = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
    exp6 = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h03, 8'h04, 8'h13, 8'h14, 8'h05, 8'h06};
    gexp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

    clk = 0; reset_n = 0; force_busy = 0; ucnt = 0; viol = 0;
    req_valid = '0; req_data = '0; req_last = '0; took = '0;
    n_chk = 0; n_err = 0;

    repeat (2) tick();
    check("rst_txStart", txStart, 0);
    check("rst_txData", txData, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_abort", abort_count, 0);
    check("rst_ready", req_ready, 0);

    // 1: single-byte packet, start pulse on the second cycle
    reset_n = 1'b1;
    tick();
    push(0, 8'h08, 1'b1);
    tick();
    check("t1_grant", grant, 2'b01);
    check("t1_busy", busy, 1);
    check("t1_nostart", txStart, 0);
    tick();
    check("t1_start", txStart, 1);
    check("t1_data", txData, 8'h08);
    tick();
    check("t1_start_off", txStart, 0);
    check("t1_pkt", pkt_count, 1);
    check("t1_grant_off", grant, 0);
    check("t1_idle", busy, 0);

    // 2: simultaneous 3-byte packets, pointer at 0 after reset
    do_reset();
    base = log_q.size();
    for (int i = 0; i < 3; i++) begin
      push(0, 8'hA0 + 8'(i), i == 2);
      push(1, 8'hB0 + 8'(i), i == 2);
    end
    wait_pkts("t2_pkt", 2, 300);
    repeat (2) tick();
    check("t2_len", log_q.size() - base, 6);
    for (int i = 0; i < 6; i++) check($sformatf("t2_byte%0d", i), log_at(base + i), exp2[i]);

    // 3: txBusy stall never times out
    do_reset();
    base = log_q.size();
    force_busy = 1'b1;
    push(0, 8'h5A, 1'b1);
    repeat (40) tick();
    check("t3_nosend", log_q.size() - base, 0);
    check("t3_noabort", abort_count, 0);
    check("t3_grant", grant, 2'b01);
    check("t3_busy", busy, 1);
    force_busy = 1'b0;
    tick();
    check("t3_start", txStart, 1);
    check("t3_data", txData, 8'h5A);
    tick();
    check("t3_pkt", pkt_count, 1);

    // 4: src1 goes quiet mid-packet; aborts on the 10th quiet cycle
    do_reset();
    push(1, 8'h77, 1'b0);
    repeat (12) tick();
    check("t4_noabort_yet", abort_count, 0);
    check("t4_grant_held", grant, 2'b10);
    tick();
    check("t4_abort", abort_count, 1);
    check("t4_grant_off", grant, 0);
    check("t4_idle", busy, 0);
    push(0, 8'h33, 1'b1);
    tick();
    check("t4_src0_grant", grant, 2'b01);
    wait_pkts("t4_pkt", 1, 50);
    repeat (2) tick();
    check("t4_byte", log_at(log_q.size() - 1), 8'h33);

    // 5: reset during HOLD of a long packet
    do_reset();
    for (int i = 0; i < 32; i++) push(0, 8'h40 + 8'(i), i == 31);
    k = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (txStart) k++;
      if (k == 4) break;
    end
    check("t5_in_hold", txStart, 1);
    reset_n = 1'b0;
    sq0.delete();
    tick();
    check("t5_txStart", txStart, 0);
    check("t5_txData", txData, 0);
    check("t5_grant", grant, 0);
    check("t5_busy", busy, 0);
    check("t5_pkt", pkt_count, 0);
    reset_n = 1'b1;
    tick();
    base = log_q.size();
    push(0, 8'hC1, 1'b0);
    push(0, 8'hC2, 1'b1);
    wait_pkts("t5_new_pkt", 1, 100);
    repeat (2) tick();
    check("t5_b0", log_at(base), 8'hC1);
    check("t5_b1", log_at(base + 1), 8'hC2);

    // 6: back-to-back src0 packets alternate with pending src1
    do_reset();
    base = log_q.size();
    for (int p = 0; p < 3; p++) begin
      push(0, 8'h01 + 8'(2*p), 1'b0);
      push(0, 8'h02 + 8'(2*p), 1'b1);
    end
    for (int p = 0; p < 2; p++) begin
      push(1, 8'h11 + 8'(2*p), 1'b0);
      push(1, 8'h12 + 8'(2*p), 1'b1);
    end
    prev = '0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (grant != 2'b00 && prev == 2'b00) gseq.push_back(grant);
      prev = grant;
      if (pkt_count == 16'd5) break;
    end
    check("t6_pkt", pkt_count, 5);
    repeat (2) tick();
    check("t6_ngrants", gseq.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t6_grant%0d", i), (i < gseq.size()) ? gseq[i] : 2'bxx, gexp[i]);
    for (int i = 0; i < 10; i++) check($sformatf("t6_byte%0d", i), log_at(base + i), exp6[i]);

    check("ready_only_granted", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
